// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and the IF/ID register. Two-word LDM instructions (opcode word followed by an
// immediate word) are merged into a single IF/ID entry, with one bubble cycle
// inserted while the immediate word is fetched.
module fetch_unit #(
  parameter int unsigned          PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [4:0]           LDM_OPCODE = 5'b00001,
  parameter logic [15:0]          NOP_INSTR  = 16'h2800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_en,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  output logic [15:0]         ifid_instr,
  output logic [15:0]         ifid_imm,
  output logic [PC_WIDTH-1:0] ifid_pc,
  output logic                ifid_valid
);

  // state     | meaning
  // S_FETCH   | next imem word is an opcode word
  // S_FETCH_IMM | next imem word is the immediate of the LDM held in pending_q
  typedef enum logic {
    S_FETCH     = 1'b0,
    S_FETCH_IMM = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         pending_q, pending_d;
  logic [15:0]         instr_q, instr_d;
  logic [15:0]         imm_q, imm_d;
  logic [PC_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic                valid_q, valid_d;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_dec;

  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign pc_dec = pc_q - PC_WIDTH'(1);

  // Next-state and IF/ID update; priority is redirect > stall > normal fetch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;

    if (redirect_en) begin
      // Any half-fetched LDM is dropped; decode sees a bubble.
      state_d   = S_FETCH;
      pc_d      = redirect_pc;
      pending_d = '0;
      instr_d   = NOP_INSTR;
      imm_d     = '0;
      valid_d   = 1'b0;
    end else if (!stall) begin
      case (state_q)
        S_FETCH: begin
          pc_d = pc_inc;
          if (imem_data[15:11] == LDM_OPCODE) begin
            pending_d = imem_data;
            state_d   = S_FETCH_IMM;
            instr_d   = NOP_INSTR;
            imm_d     = '0;
            valid_d   = 1'b0;
          end else begin
            instr_d   = imem_data;
            imm_d     = '0;
            ifid_pc_d = pc_q;
            valid_d   = 1'b1;
          end
        end
        S_FETCH_IMM: begin
          // The immediate word is taken verbatim, never decoded as an opcode.
          pc_d      = pc_inc;
          state_d   = S_FETCH;
          instr_d   = pending_q;
          imm_d     = imem_data;
          ifid_pc_d = pc_dec;
          valid_d   = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State, PC and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      pending_q <= '0;
      instr_q   <= NOP_INSTR;
      imm_q     <= '0;
      ifid_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_imm   = imm_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight-line fetch, LDM merge, stall,
// redirect-over-stall, asynchronous reset mid-LDM and PC wrap-around.
module tb_fetch_unit;

  logic        clk;
  logic        rst, rst2;
  logic        stall, redirect_en;
  logic [15:0] redirect_pc;

  logic [15:0] imem_addr, imem_data, ifid_instr, ifid_imm, ifid_pc;
  logic        ifid_valid;
  logic [15:0] imem_addr2, imem_data2, ifid_instr2, ifid_imm2, ifid_pc2;
  logic        ifid_valid2;

  logic [15:0] mem  [0:65535];
  logic [15:0] mem2 [0:65535];

  int n_chk  = 0;
  int n_pass = 0;

  assign imem_data  = mem[imem_addr];
  assign imem_data2 = mem2[imem_addr2];

  fetch_unit u_dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .ifid_instr  (ifid_instr),
    .ifid_imm    (ifid_imm),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk         (clk),
    .rst         (rst2),
    .stall       (1'b0),
    .redirect_en (1'b0),
    .redirect_pc (16'h0000),
    .imem_addr   (imem_addr2),
    .imem_data   (imem_data2),
    .ifid_instr  (ifid_instr2),
    .ifid_imm    (ifid_imm2),
    .ifid_pc     (ifid_pc2),
    .ifid_valid  (ifid_valid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string tag, input logic [15:0] instr,
                           input logic [15:0] imm, input logic [15:0] pc,
                           input logic valid);
    chk({tag, ".instr"}, {16'h0, ifid_instr}, {16'h0, instr});
    chk({tag, ".imm"},   {16'h0, ifid_imm},   {16'h0, imm});
    chk({tag, ".pc"},    {16'h0, ifid_pc},    {16'h0, pc});
    chk({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, valid});
  endtask

  task automatic redirect_to(input logic [15:0] target);
    redirect_en = 1'b1;
    redirect_pc = target;
    tick();
    redirect_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = 16'h3000;
      mem2[i] = 16'h3000;
    end
    mem[0]  = 16'h1800;
    mem[1]  = 16'h2000;
    mem[2]  = 16'h1000;
    mem[4]  = 16'h0800;
    mem[5]  = 16'h00AB;
    mem[6]  = 16'h1800;
    mem[16] = 16'h1C00;
    mem2[16'hFFFF] = 16'h0800;
    mem2[0]        = 16'h1234;
    mem2[1]        = 16'h1800;

    rst = 1'b1; rst2 = 1'b1;
    stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    #12;
    chk("rst.addr", {16'h0, imem_addr}, 32'h0);
    chk_entry("rst", 16'h2800, 16'h0, 16'h0, 1'b0);
    rst = 1'b0;

    // straight-line
    tick(); chk_entry("sl1", 16'h1800, 16'h0, 16'h0, 1'b1);
    chk("sl1.addr", {16'h0, imem_addr}, 32'h1);
    tick(); chk_entry("sl2", 16'h2000, 16'h0, 16'h1, 1'b1);
    tick(); chk_entry("sl3", 16'h1000, 16'h0, 16'h2, 1'b1);
    chk("sl3.addr", {16'h0, imem_addr}, 32'h3);

    // LDM merge
    redirect_to(16'h0004);
    chk("redir.valid", {31'h0, ifid_valid}, 32'h0);
    chk("ldm.addr0", {16'h0, imem_addr}, 32'h4);
    tick(); chk("ldm1.valid", {31'h0, ifid_valid}, 32'h0);
    chk("ldm1.instr", {16'h0, ifid_instr}, 32'h2800);
    chk("ldm1.addr", {16'h0, imem_addr}, 32'h5);
    tick(); chk_entry("ldm2", 16'h0800, 16'h00AB, 16'h4, 1'b1);
    chk("ldm2.addr", {16'h0, imem_addr}, 32'h6);
    tick(); chk_entry("ldm3", 16'h1800, 16'h0, 16'h6, 1'b1);
    chk("ldm3.addr", {16'h0, imem_addr}, 32'h7);

    // stall in FETCH_IMM
    redirect_to(16'h0004);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.addr", {16'h0, imem_addr}, 32'h5);
      chk("stall.valid", {31'h0, ifid_valid}, 32'h0);
      chk("stall.instr", {16'h0, ifid_instr}, 32'h2800);
    end
    stall = 1'b0;
    tick(); chk_entry("unstall", 16'h0800, 16'h00AB, 16'h4, 1'b1);

    // redirect beats stall in FETCH_IMM
    redirect_to(16'h0004);
    tick();
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 16'h0010;
    tick();
    stall = 1'b0; redirect_en = 1'b0;
    chk("rbs.addr", {16'h0, imem_addr}, 32'h10);
    chk("rbs.valid", {31'h0, ifid_valid}, 32'h0);
    chk("rbs.instr", {16'h0, ifid_instr}, 32'h2800);
    tick(); chk_entry("rbs1", 16'h1C00, 16'h0, 16'h10, 1'b1);
    tick(); chk_entry("rbs2", 16'h3000, 16'h0, 16'h11, 1'b1);

    // asynchronous reset between edges while in FETCH_IMM
    redirect_to(16'h0004);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst.addr", {16'h0, imem_addr}, 32'h0);
    chk_entry("arst", 16'h2800, 16'h0, 16'h0, 1'b0);
    rst = 1'b0;
    tick(); chk_entry("arst1", 16'h1800, 16'h0, 16'h0, 1'b1);

    // wrap-around with RESET_PC = FFFF
    #3;
    chk("wrap.addr0", {16'h0, imem_addr2}, 32'hFFFF);
    rst2 = 1'b0;
    tick();
    chk("wrap1.valid", {31'h0, ifid_valid2}, 32'h0);
    chk("wrap1.addr", {16'h0, imem_addr2}, 32'h0);
    tick();
    chk("wrap2.instr", {16'h0, ifid_instr2}, 32'h0800);
    chk("wrap2.imm",   {16'h0, ifid_imm2},   32'h1234);
    chk("wrap2.pc",    {16'h0, ifid_pc2},    32'hFFFF);
    chk("wrap2.valid", {31'h0, ifid_valid2}, 32'h1);
    chk("wrap2.addr",  {16'h0, imem_addr2},  32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
